// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, hides the one-cycle registered imem
// latency and presents an IF/ID register with stall, redirect/kill and sticky faults.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IMEM_SIZE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic [31:0] imemAddress,
    input  logic [31:0] imemInstruction,
    output logic [31:0] ifidInstruction,
    output logic [31:0] ifidPc,
    output logic        ifidValid,
    output logic        misalignedFault,
    output logic        rangeFault,
    output logic [31:0] fetchCount
);

    localparam logic [31:0] LAST_WORD = 32'(IMEM_SIZE - 1);

    logic [31:0] pc_q, pc_d;
    logic [31:0] f2_pc_q, f2_pc_d;
    logic        f2_valid_q, f2_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        range_q, range_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] f2_data;
    logic        out_of_range;

    always_comb begin
        pc_d          = pc_q;
        f2_pc_d       = f2_pc_q;
        f2_valid_d    = f2_valid_q;
        hold_instr_d  = hold_instr_q;
        hold_valid_d  = hold_valid_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_valid_d  = ifid_valid_q;
        misaligned_d  = misaligned_q;
        range_d       = range_q;
        fetch_count_d = fetch_count_q;

        // Once stalled, the memory output tracks pcReg, so F2 data comes from the hold buffer.
        f2_data      = hold_valid_q ? hold_instr_q : imemInstruction;
        out_of_range = (pc_q >> 2) > LAST_WORD;

        if (!stall && out_of_range) begin
            range_d = 1'b1;
        end

        if (redirectValid) begin
            pc_d         = {redirectTarget[31:2], 2'b00};
            f2_valid_d   = 1'b0;
            ifid_valid_d = 1'b0;
            hold_valid_d = 1'b0;
            if (redirectTarget[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
            end
        end else if (stall) begin
            if (!hold_valid_q && f2_valid_q) begin
                hold_instr_d = imemInstruction;
                hold_valid_d = 1'b1;
            end
        end else begin
            pc_d         = pc_q + 32'd4;
            f2_pc_d      = pc_q;
            f2_valid_d   = 1'b1;
            ifid_instr_d = f2_data;
            ifid_pc_d    = f2_pc_q;
            ifid_valid_d = f2_valid_q;
            hold_valid_d = 1'b0;
            if (f2_valid_q) begin
                fetch_count_d = fetch_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            f2_pc_q       <= '0;
            f2_valid_q    <= 1'b0;
            hold_instr_q  <= '0;
            hold_valid_q  <= 1'b0;
            ifid_instr_q  <= '0;
            ifid_pc_q     <= '0;
            ifid_valid_q  <= 1'b0;
            misaligned_q  <= 1'b0;
            range_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            f2_pc_q       <= f2_pc_d;
            f2_valid_q    <= f2_valid_d;
            hold_instr_q  <= hold_instr_d;
            hold_valid_q  <= hold_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_valid_q  <= ifid_valid_d;
            misaligned_q  <= misaligned_d;
            range_q       <= range_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imemAddress     = pc_q;
    assign ifidInstruction = ifid_instr_q;
    assign ifidPc          = ifid_pc_q;
    assign ifidValid       = ifid_valid_q;
    assign misalignedFault = misaligned_q;
    assign rangeFault      = range_q;
    assign fetchCount      = fetch_count_q;

endmodule
